// File: rtl/ifmap_skew_feeder.sv
// Input feature-map skew feeder: delays row r of each accepted vector by r+1 cycles and
// enforces tile boundaries with a drain phase. Optional macro: SKEW_ZERO_FILL_EN.
module ifmap_skew_feeder #(
  parameter int unsigned WORDWIDTH = 32,
  parameter int unsigned ROWS      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*WORDWIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic [ROWS*WORDWIDTH-1:0] F_out,
  output logic [ROWS-1:0]           gate_out,
  output logic                      tile_done,
  output logic                      busy
);

  localparam int unsigned CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            in_ready_d;
  logic            tile_done_d;
  logic            busy_d;
  logic [ROWS-1:0] pend;

  assign accept = in_valid && in_ready;

  // Control state register plus registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin : p_ctrl
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      in_ready  <= 1'b0;
      tile_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_ready  <= in_ready_d;
      tile_done <= tile_done_d;
      busy      <= busy_d;
    end
  end

  // Next-state logic; tile_done lines up with the last diagonal reaching lane ROWS-1
  always_comb begin : p_next
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_STREAM: begin
        if (accept) begin
          if (in_last) begin
            state_d = S_DRAIN;
            cnt_d   = CW'(ROWS - 1);
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    in_ready_d  = (state_d != S_DRAIN);
    tile_done_d = (state_d == S_DRAIN) && (cnt_d == '0);
    busy_d      = (state_d != S_IDLE) || accept || (|pend);
  end

  // Per-lane delay chains; lane r holds r+1 stages
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [WORDWIDTH-1:0] d_q [r+1];
    logic [r:0]           v_q;
    logic [WORDWIDTH-1:0] din;

    assign din = in_data[r*WORDWIDTH +: WORDWIDTH];

    always_ff @(posedge clk or posedge rst) begin : p_stage
      if (rst) begin
        v_q <= '0;
        for (int s = 0; s <= r; s++) begin
          d_q[s] <= '0;
        end
      end else begin
        v_q[0] <= accept;
        for (int s = 1; s <= r; s++) begin
          v_q[s] <= v_q[s-1];
        end
`ifdef SKEW_ZERO_FILL_EN
        d_q[0] <= accept ? din : '0;
        for (int s = 1; s <= r; s++) begin
          d_q[s] <= d_q[s-1];
        end
`else
        // Clock-enabled on valid so bubbles leave the last word parked on F
        if (accept) begin
          d_q[0] <= din;
        end
        for (int s = 1; s <= r; s++) begin
          if (v_q[s-1]) begin
            d_q[s] <= d_q[s-1];
          end
        end
`endif
      end
    end

    assign F_out[r*WORDWIDTH +: WORDWIDTH] = d_q[r];
    assign gate_out[r]                     = v_q[r];

    // Valid data still upstream of the lane output keeps busy asserted
    if (r == 0) begin : g_p0
      assign pend[r] = 1'b0;
    end else begin : g_pn
      assign pend[r] = |v_q[r-1:0];
    end
  end

endmodule
